// File: rtl/ps2_pkg.sv
// Shared constants, field indices and frame-state encoding for the PS/2 key encoder.
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_E0 = 8'hE0;
    localparam logic [7:0] PS2_PFX_F0 = 8'hF0;
    localparam logic [7:0] PS2_PFX_E1 = 8'hE1;
    localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;

    localparam int unsigned KEY_TOGGLE  = 10;
    localparam int unsigned KEY_PRESSED = 9;
    localparam int unsigned KEY_EXT     = 8;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_e;

    // Keyboard housekeeping replies (ack, resend, BAT, echo, overrun)
    function automatic logic is_drop_code(input logic [7:0] b);
        return (b == 8'hFA) || (b == 8'hFE) || (b == 8'hAA) ||
               (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 serial receiver: pin synchronisers, glitch filters, 11-bit frame FSM and
// in-frame timeout. Emits one byte_valid_o pulse per good frame, err_o otherwise.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 96000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       err_o
);

    localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

    // Index 0 is the PS/2 clock line, index 1 the data line
    logic [1:0]     raw;
    logic [1:0]     sync1_q, sync2_q, filt_q;
    logic [FCW-1:0] fcnt_q [2];
    logic           clk_prev_q;
    logic           strobe;
    logic           data_bit;

    frame_state_e   state_q, state_d;
    logic [7:0]     shift_q;
    logic [2:0]     bitcnt_q;
    logic           par_q;
    logic [TW-1:0]  tmo_q;
    logic           timeout_hit;
    logic           frame_ok;
    logic           valid_d, err_d;
    logic           valid_q, err_q;

    assign raw = {ps2_data_i, ps2_clk_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            filt_q     <= '1;
            fcnt_q[0]  <= '0;
            fcnt_q[1]  <= '0;
            clk_prev_q <= 1'b1;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            clk_prev_q <= filt_q[0];
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FCW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign strobe      = clk_prev_q & ~filt_q[0];
    assign data_bit    = filt_q[1];
    assign timeout_hit = (state_q != IDLE) && !strobe && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign frame_ok    = (^{shift_q, par_q}) && data_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (strobe && !data_bit) state_d = DATA;
            DATA:    if (strobe && bitcnt_q == 3'd7) state_d = PARITY;
            PARITY:  if (strobe) state_d = STOP;
            STOP:    if (strobe) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout_hit) state_d = IDLE;
    end

    always_comb begin
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (state_q == STOP && strobe) begin
            valid_d = frame_ok;
            err_d   = !frame_ok;
        end
        if (timeout_hit) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            if (state_q == IDLE || strobe) tmo_q <= '0;
            else                           tmo_q <= tmo_q + 1'b1;
            if (strobe) begin
                unique case (state_q)
                    IDLE:   bitcnt_q <= '0;
                    DATA: begin
                        shift_q  <= {data_bit, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                    end
                    PARITY: par_q <= data_bit;
                    default: ;
                endcase
            end
        end
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = valid_q;
    assign err_o        = err_q;

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 set-2 key encoder: strips E0/F0/E1 prefixes from received bytes and emits
// one toggle-strobed 11-bit event per key make or break.
module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 96000,
    parameter int unsigned PAUSE_SKIP     = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int unsigned SW = (PAUSE_SKIP > 0) ? $clog2(PAUSE_SKIP + 1) : 1;

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_err;

    logic [10:0]   key_q, key_d;
    logic          ext_q, ext_d;
    logic          rel_q, rel_d;
    logic [SW-1:0] skip_q, skip_d;

    ps2_rx_frame #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .err_o       (rx_err)
    );

    // Pause skip takes priority over every other decode, including a repeated E1
    always_comb begin
        key_d  = key_q;
        ext_d  = ext_q;
        rel_d  = rel_q;
        skip_d = skip_q;
        if (rx_err) begin
            ext_d  = 1'b0;
            rel_d  = 1'b0;
            skip_d = '0;
        end else if (rx_valid) begin
            if (skip_q != '0) begin
                skip_d = skip_q - 1'b1;
            end else if (rx_byte == PS2_PFX_E1) begin
                skip_d = SW'(PAUSE_SKIP);
                key_d  = {~key_q[KEY_TOGGLE], 1'b1, 1'b1, PS2_PAUSE_CODE};
                ext_d  = 1'b0;
                rel_d  = 1'b0;
            end else if (rx_byte == PS2_PFX_E0) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_PFX_F0) begin
                rel_d = 1'b1;
            end else if (!(is_drop_code(rx_byte) && !ext_q && !rel_q)) begin
                key_d = {~key_q[KEY_TOGGLE], ~rel_q, ext_q, rx_byte};
                ext_d = 1'b0;
                rel_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q  <= '0;
            ext_q  <= 1'b0;
            rel_q  <= 1'b0;
            skip_q <= '0;
        end else begin
            key_q  <= key_d;
            ext_q  <= ext_d;
            rel_q  <= rel_d;
            skip_q <= skip_d;
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = rx_err;

endmodule
